// File: rtl/mxint_dequant_pkg.sv
// mxint_pkg: shared helpers for the MxInt dequantizer.
//   ebias(width)        biased-exponent offset 2^(width-1)-1
//   sh_width(e, m, f)   signed width needed to hold the shift amount for any exponent
//   sat_max/sat_min     symmetric saturation limits for a signed result width
package mxint_pkg;

    function automatic int ebias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Starts at exp_w+2 and grows until every reachable shift amount fits,
    // so the shift computation can never wrap.
    function automatic int sh_width(input int exp_w, input int man_w, input int frac_w);
        int lo;
        int hi;
        int w;
        lo = -ebias(exp_w) - man_w + 2 + frac_w;
        hi = (1 << exp_w) - 1 - ebias(exp_w) - man_w + 2 + frac_w;
        w  = exp_w + 2;
        while (lo < -(1 << (w - 1)) || hi > (1 << (w - 1)) - 1)
            w++;
        return w;
    endfunction

    function automatic int sat_max(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int out_w);
        return -sat_max(out_w);
    endfunction

endpackage

// File: rtl/mxint_dequant_lane.sv
// mxint_dequant_lane: combinational per-element shift (and optional clamp).
//   m   signed mantissa
//   sh  signed shift amount (positive = left)
//   y   signed fixed-point result
// MXINT_DEQUANT_SAT_EN selects symmetric saturation; otherwise the result wraps.
module mxint_dequant_lane
    import mxint_pkg::*;
#(
    parameter int MW  = 8,
    parameter int SHW = 10,
    parameter int OW  = 16
) (
    input  logic signed [MW-1:0]  m,
    input  logic signed [SHW-1:0] sh,
    output logic signed [OW-1:0]  y
);

`ifdef MXINT_DEQUANT_SAT_EN
    // Wide enough that m << (OW+1) is exact: any nonzero m shifted that far
    // is already out of range, so larger shifts are clamped to it.
    localparam int EXT_W   = OW + MW + 1;
    localparam int LSH_MAX = OW + 1;
    localparam logic signed [EXT_W-1:0] HI_LIM = EXT_W'(sat_max(OW));
    localparam logic signed [EXT_W-1:0] LO_LIM = EXT_W'(sat_min(OW) - 1);
    localparam logic signed [OW-1:0]    Y_MAX  = OW'(sat_max(OW));
    localparam logic signed [OW-1:0]    Y_MIN  = OW'(sat_min(OW));
`else
    // Wrapping keeps only the low OW bits of the exact product, and those
    // bits do not depend on anything above them, so OW bits of headroom suffice.
    localparam int EXT_W   = OW;
    localparam int LSH_MAX = OW;
`endif

    logic signed [EXT_W-1:0] m_ext;
    logic signed [EXT_W-1:0] shifted;
    int                      amt;

    always_comb begin
        m_ext = EXT_W'(m);
        amt   = int'(sh);
        if (amt >= 0)
            shifted = m_ext <<< ((amt > LSH_MAX) ? LSH_MAX : amt);
        else
            // Beyond MW-1 the arithmetic shift has already collapsed to 0 / -1.
            shifted = m_ext >>> ((-amt >= MW) ? (MW - 1) : -amt);
`ifdef MXINT_DEQUANT_SAT_EN
        if (shifted > HI_LIM)
            y = Y_MAX;
        else if (shifted < LO_LIM)
            y = Y_MIN;
        else
            y = shifted[OW-1:0];
`else
        y = shifted[OW-1:0];
`endif
    end

endmodule

// File: rtl/mxint_dequant.sv
// mxint_dequant: 2-stage valid/ready MxInt block -> fixed-point dequantizer.
//   clk, rst                     clock, async active-high reset
//   mdata_in[BLOCK_SIZE]         signed mantissas
//   edata_in                     shared biased exponent
//   data_in_valid/data_in_ready  input handshake
//   data_out[BLOCK_SIZE]         signed fixed-point results
//   data_out_valid/data_out_ready output handshake
// Build option: define MXINT_DEQUANT_SAT_EN for symmetric saturation on
// overflow; undefined, overflowing results wrap to OUT_WIDTH bits.
module mxint_dequant
    import mxint_pkg::*;
#(
    parameter int IN_MAN_WIDTH   = 8,
    parameter int IN_EXP_WIDTH   = 8,
    parameter int OUT_WIDTH      = 16,
    parameter int OUT_FRAC_WIDTH = 8,
    parameter int BLOCK_SIZE     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE],
    input  logic [IN_EXP_WIDTH-1:0]     edata_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out [BLOCK_SIZE],
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    localparam int SHW    = sh_width(IN_EXP_WIDTH, IN_MAN_WIDTH, OUT_FRAC_WIDTH);
    localparam int SH_OFS = ebias(IN_EXP_WIDTH) + IN_MAN_WIDTH - 2 - OUT_FRAC_WIDTH;

    logic                          s1_valid;
    logic signed [IN_MAN_WIDTH-1:0] s1_man [BLOCK_SIZE];
    logic signed [SHW-1:0]         s1_sh;
    logic signed [SHW-1:0]         sh_in;
    logic signed [OUT_WIDTH-1:0]   lane_y [BLOCK_SIZE];
    logic                          s2_advance;

    assign sh_in = SHW'(signed'({1'b0, edata_in})) - SHW'(SH_OFS);

    // Ready looks through to data_out_ready so a full pipe can still move
    // one beat in and one beat out in the same cycle.
    assign s2_advance    = !data_out_valid || data_out_ready;
    assign data_in_ready = !s1_valid || s2_advance;

    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
        mxint_dequant_lane #(
            .MW (IN_MAN_WIDTH),
            .SHW(SHW),
            .OW (OUT_WIDTH)
        ) u_lane (
            .m (s1_man[i]),
            .sh(s1_sh),
            .y (lane_y[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_sh          <= '0;
            data_out_valid <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                s1_man[i]   <= '0;
                data_out[i] <= '0;
            end
        end else begin
            if (data_in_ready) begin
                s1_valid <= data_in_valid;
                if (data_in_valid) begin
                    s1_sh <= sh_in;
                    for (int i = 0; i < BLOCK_SIZE; i++)
                        s1_man[i] <= mdata_in[i];
                end
            end
            if (s2_advance) begin
                data_out_valid <= s1_valid;
                if (s1_valid) begin
                    for (int i = 0; i < BLOCK_SIZE; i++)
                        data_out[i] <= lane_y[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mxint_dequant.sv
// Scoreboard bench for mxint_dequant: the driver issues blocks, the input
// monitor queues the reference result on each accept, and the output monitor
// pops and compares on each emitted beat.
module tb_mxint_dequant;

    localparam int MW = 8;
    localparam int OW = 16;
    localparam int BS = 4;
    localparam int EBIAS = 127;
    localparam int FRAC = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [MW-1:0] mdata_in [BS];
    logic [7:0]           edata_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
    logic signed [OW-1:0] data_out [BS];
    logic                 data_out_valid;
    logic                 data_out_ready;

    mxint_dequant dut (
        .clk           (clk),
        .rst           (rst),
        .mdata_in      (mdata_in),
        .edata_in      (edata_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y[BS];
        int acc;
        bit lat;
    } exp_t;

    exp_t q[$];
    exp_t cur_exp;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   cyc      = 0;
    bit   held_valid = 0;
    int   held[BS];
    bit   rand_ready_on = 0;

    always @(posedge clk) cyc++;

    task automatic check(input bit ok, input string name, input string detail);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    // y = floor(m * 2^(e - EBIAS - (MW-2)) * 2^FRAC), then overflow policy.
    function automatic int model_y(input int m, input int e);
        int  sh;
        real s;
        real r;
        longint p;
        logic signed [OW-1:0] t;
        sh = e - EBIAS - (MW - 2) + FRAC;
        s = 1.0;
        if (sh >= 0) repeat (sh) s = s * 2.0;
        else repeat (-sh) s = s / 2.0;
        r = $floor(m * s);
        if (r <= 32767.0 && r >= -32768.0) return int'(r);
`ifdef MXINT_DEQUANT_SAT_EN
        return (r > 0.0) ? 32767 : -32767;
`else
        if (sh >= OW) return 0;
        p = longint'(m) * (longint'(1) << sh);
        t = p[OW-1:0];
        return int'(t);
`endif
    endfunction

    function automatic string fmt4(input int a[BS]);
        return $sformatf("{%0d,%0d,%0d,%0d}", a[0], a[1], a[2], a[3]);
    endfunction

    // Monitors: sampled at negedge, half a cycle away from the active edge.
    always @(negedge clk) begin
        int got[BS];
        exp_t e;
        bit   exp_rdy;
        if (!rst) begin
            for (int i = 0; i < BS; i++) got[i] = int'(data_out[i]);
            // Two blocks in flight means both stages are occupied.
            exp_rdy = !(q.size() == 2 && !data_out_ready);
            check(data_in_ready == exp_rdy, "in_ready",
                  $sformatf("got %0b exp %0b (inflight %0d)", data_in_ready, exp_rdy, q.size()));
            if (data_out_valid) begin
                if (held_valid)
                    check(got == held, "stall_stable",
                          $sformatf("got %s exp %s", fmt4(got), fmt4(held)));
                if (data_out_ready) begin
                    held_valid = 0;
                    if (q.size() == 0) begin
                        check(1'b0, "spurious_out", $sformatf("got %s with empty scoreboard", fmt4(got)));
                    end else begin
                        e = q.pop_front();
                        check(got == e.y, "data", $sformatf("got %s exp %s", fmt4(got), fmt4(e.y)));
                        if (e.lat)
                            check(cyc == e.acc + 1, "latency",
                                  $sformatf("out at edge %0d exp %0d", cyc, e.acc + 1));
                    end
                end else begin
                    held_valid = 1;
                    held = got;
                end
            end else if (held_valid) begin
                check(1'b0, "stall_valid_drop", "data_out_valid fell while stalled");
                held_valid = 0;
            end
            if (data_in_valid && data_in_ready) begin
                e = cur_exp;
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic send(input int m[BS], input int e, input int ey[BS], input bit lat);
        bit acc;
        int t;
        for (int i = 0; i < BS; i++) mdata_in[i] = MW'(m[i]);
        edata_in = 8'(e);
        cur_exp.y = ey;
        cur_exp.lat = lat;
        data_in_valid = 1'b1;
        t = 0;
        acc = 0;
        while (!acc) begin
            @(negedge clk);
            acc = data_in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 200) begin
                check(1'b0, "accept_timeout", "input not accepted within 200 cycles");
                acc = 1;
            end
        end
        data_in_valid = 1'b0;
    endtask

    task automatic send_model(input int m[BS], input int e, input bit lat);
        int ey[BS];
        for (int i = 0; i < BS; i++) ey[i] = model_y(m[i], e);
        send(m, e, ey, lat);
    endtask

    task automatic rand_block(output int m[BS], output int e);
        for (int i = 0; i < BS; i++) m[i] = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 255));
        else e = int'($urandom_range(100, 145));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(q.size() == 0, "drain", $sformatf("%0d blocks still outstanding", q.size()));
    endtask

    initial begin
        int dm[BS];
        int dy[BS];
        int m[BS];
        int e;
        rst = 1'b1;
        data_in_valid = 1'b0;
        data_out_ready = 1'b1;
        edata_in = '0;
        for (int i = 0; i < BS; i++) mdata_in[i] = '0;
        #2;
        check(data_out_valid == 1'b0, "reset_valid", $sformatf("got %0b exp 0", data_out_valid));
        for (int i = 0; i < BS; i++) dy[i] = int'(data_out[i]);
        dm = '{0, 0, 0, 0};
        check(dy == dm, "reset_data", $sformatf("got %s exp all 0", fmt4(dy)));
        #20;
        rst = 1'b0;
        #1;
        check(data_in_ready == 1'b1, "ready_after_reset", $sformatf("got %0b exp 1", data_in_ready));
        @(posedge clk);
        #1;

        // Directed vectors.
        dm = '{64, -64, 1, 0};   dy = '{256, -256, 4, 0};
        send(dm, 127, dy, 1'b1);
        drain();
        dm = '{-64, 63, -1, 1};  dy = '{-2, 1, -1, 0};
        send(dm, 120, dy, 1'b1);
        dm = '{5, -5, 0, -128};  dy = '{0, -1, 0, -1};
        send(dm, 100, dy, 1'b1);
        dm = '{101, -101, 0, 1};
`ifdef MXINT_DEQUANT_SAT_EN
        dy = '{32767, -32767, 0, 32767};
`else
        dy = '{-32768, -32768, 0, -32768};
`endif
        send(dm, 140, dy, 1'b1);
        drain();

        // Back-to-back, no stall: each output exactly one edge after stage 1 loads.
        for (int n = 0; n < 16; n++) begin
            rand_block(m, e);
            send_model(m, e, 1'b1);
        end
        drain();

        // Random valid and ready.
        rand_ready_on = 1;
        fork
            begin
                while (rand_ready_on) begin
                    @(posedge clk);
                    #1;
                    if (rand_ready_on) data_out_ready = $urandom_range(0, 1) == 1;
                end
            end
        join_none
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            rand_block(m, e);
            send_model(m, e, 1'b0);
        end
        rand_ready_on = 0;
        @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        drain();

        // Fill both stages under stall, then reset mid-stream.
        data_out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rand_block(m, e);
            send_model(m, e, 1'b0);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(data_out_valid == 1'b0, "async_reset_valid", $sformatf("got %0b exp 0", data_out_valid));
        for (int i = 0; i < BS; i++) dy[i] = int'(data_out[i]);
        dm = '{0, 0, 0, 0};
        check(dy == dm, "async_reset_data", $sformatf("got %s exp all 0", fmt4(dy)));
        q.delete();
        held_valid = 0;
        data_out_ready = 1'b1;
        #20;
        rst = 1'b0;
        #1;
        check(data_in_ready == 1'b1, "ready_after_midreset", $sformatf("got %0b exp 1", data_in_ready));
        @(posedge clk);
        #1;
        rand_block(m, e);
        send_model(m, e, 1'b1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
